// File: rtl/masked_psum_accumulator.sv
// Walks a captured adder-mask beat row by row and streams one signed partial-sum
// reduction per nonzero row (filter group) over a valid/ready output.
module masked_psum_accumulator #(
  parameter int NUM_MACRO = 16,
  parameter int OUT_CH    = 512,
  parameter int PSUM_W    = 16,
  localparam int BIT_OUT_CH = $clog2(OUT_CH),
  localparam int SUM_W      = PSUM_W + $clog2(NUM_MACRO)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_MACRO*NUM_MACRO-1:0]  ADDER_MASK,
  input  logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER,
  input  logic [NUM_MACRO*PSUM_W-1:0]     PSUM,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [SUM_W-1:0]         out_sum,
  output logic [BIT_OUT_CH-1:0]           out_filter,
  output logic                            out_last,
  output logic                            empty_done,
  output logic [1:0]                      dbg_state
);

  localparam int PTR_W = (NUM_MACRO > 1) ? $clog2(NUM_MACRO) : 1;
  localparam int EXT_W = SUM_W - PSUM_W;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(NUM_MACRO - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; once
  // out_valid rises, out_sum/out_filter/out_last hold until that transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, OUT = 2'd2} state_t;

  state_t                          state, state_nxt;
  logic [PTR_W-1:0]                ptr, ptr_nxt;
  logic [NUM_MACRO*NUM_MACRO-1:0]  mask_q;
  logic [NUM_MACRO*BIT_OUT_CH-1:0] filt_q;
  logic [NUM_MACRO*PSUM_W-1:0]     psum_q;
  logic                            emitted;
  logic [NUM_MACRO-1:0]            cur_row;
  logic                            later_nz;
  logic signed [SUM_W-1:0]         row_sum;
  logic [PSUM_W-1:0]               psum_j;
  logic                            take, load_out;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign dbg_state = state;

  // Row datapath: current row, its masked sum, and whether any later row is nonzero.
  always_comb begin
    cur_row  = mask_q[int'(ptr)*NUM_MACRO +: NUM_MACRO];
    later_nz = 1'b0;
    row_sum  = '0;
    psum_j   = '0;
    for (int r = 0; r < NUM_MACRO; r++) begin
      if ((r > int'(ptr)) && (|mask_q[r*NUM_MACRO +: NUM_MACRO])) later_nz = 1'b1;
    end
    for (int j = 0; j < NUM_MACRO; j++) begin
      psum_j = psum_q[j*PSUM_W +: PSUM_W];
      if (cur_row[j]) row_sum = row_sum + {{EXT_W{psum_j[PSUM_W-1]}}, psum_j};
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    take       = 1'b0;
    load_out   = 1'b0;
    empty_done = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          take      = 1'b1;
          ptr_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (|cur_row) begin
          load_out  = 1'b1;
          state_nxt = OUT;
        end else if (ptr != LAST_ROW) begin
          ptr_nxt = ptr + PTR_W'(1);
        end else begin
          state_nxt  = IDLE;
          empty_done = !emitted;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (out_last) begin
            state_nxt = IDLE;
          end else begin
            ptr_nxt   = ptr + PTR_W'(1);
            state_nxt = SCAN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      mask_q     <= '0;
      filt_q     <= '0;
      psum_q     <= '0;
      emitted    <= 1'b0;
      out_sum    <= '0;
      out_filter <= '0;
      out_last   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (take) begin
        mask_q  <= ADDER_MASK;
        filt_q  <= WHICH_FILTER;
        psum_q  <= PSUM;
        emitted <= 1'b0;
      end
      if (load_out) begin
        out_sum    <= row_sum;
        out_filter <= filt_q[int'(ptr)*BIT_OUT_CH +: BIT_OUT_CH];
        out_last   <= !later_nz;
        emitted    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_masked_psum_accumulator.sv
// Directed bench for masked_psum_accumulator (4 macros, 8-bit psums): a scoreboard
// queue of expected {sum, filter, last} results, popped by a negedge monitor.
module tb_masked_psum_accumulator;

  localparam int NM = 4;
  localparam int PW = 8;
  localparam int OC = 512;
  localparam int FW = 9;
  localparam int SW = 10;
  localparam int EW = SW + FW + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NM*NM-1:0]  adder_mask = '0;
  logic [NM*FW-1:0]  which_filter = '0;
  logic [NM*PW-1:0]  psum = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [SW-1:0]     out_sum;
  logic [FW-1:0]     out_filter;
  logic              out_last;
  logic              empty_done;
  logic [1:0]        dbg_state;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int empty_cnt = 0;

  masked_psum_accumulator #(.NUM_MACRO(NM), .OUT_CH(OC), .PSUM_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ADDER_MASK(adder_mask), .WHICH_FILTER(which_filter), .PSUM(psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_filter(out_filter), .out_last(out_last), .empty_done(empty_done),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] mk(input int s, input int f, input bit l);
    logic [SW-1:0] s10;
    logic [FW-1:0] f9;
    s10 = SW'(s);
    f9  = FW'(f);
    return {s10, f9, l};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (empty_done) empty_cnt++;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got %0h expected none", {out_sum, out_filter, out_last});
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_sum, out_filter, out_last} !== e) begin
          failures++;
          $display("FAIL result: got sum=%0h filt=%0d last=%0b expected sum=%0h filt=%0d last=%0b",
                   out_sum, out_filter, out_last, e[EW-1 -: SW], e[FW:1], e[0]);
        end
      end
    end
  end

  // driver tasks
  task automatic set_beat(input logic [3:0] r0, r1, r2, r3,
                          input int f0, f1, f2, f3, input int p0, p1, p2, p3);
    adder_mask   = {r3, r2, r1, r0};
    which_filter = {FW'(f3), FW'(f2), FW'(f1), FW'(f0)};
    psum         = {PW'(p3), PW'(p2), PW'(p1), PW'(p0)};
  endtask

  task automatic send_beat();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(output int ir_high);
    int n;
    n = 0;
    ir_high = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      if (exp_q.size() != 0 && in_ready) ir_high++;
      n++;
    end
    check("drain_done", exp_q.size(), 32'd0);
    @(negedge clk);
    check("in_ready_after_last", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int ir_high;
    int n;

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_sum", {22'b0, out_sum}, 32'd0);
    check("rst_out_filter", {23'b0, out_filter}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_empty_done", {31'b0, empty_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // two groups
    set_beat(4'b1011, 4'b0000, 4'b0100, 4'b0000, 5, 5, 7, 5, 10, -3, 20, 4);
    exp_q.push_back(mk(11, 5, 1'b0));
    exp_q.push_back(mk(20, 7, 1'b1));
    send_beat();
    @(negedge clk);
    check("lat_cycle1_no_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    drain(ir_high);
    check("two_groups_no_empty", empty_cnt, 32'd0);

    // all distinct, extremes of PSUM
    set_beat(4'b0001, 4'b0010, 4'b0100, 4'b1000, 1, 2, 3, 4, -128, -128, 127, 1);
    exp_q.push_back(mk(-128, 1, 1'b0));
    exp_q.push_back(mk(-128, 2, 1'b0));
    exp_q.push_back(mk(127, 3, 1'b0));
    exp_q.push_back(mk(1, 4, 1'b1));
    send_beat();
    drain(ir_high);
    check("distinct_in_ready_low", ir_high, 32'd0);

    // single group, full row of most-negative values
    set_beat(4'b1111, 4'b0000, 4'b0000, 4'b0000, 9, 1, 2, 3, -128, -128, -128, -128);
    exp_q.push_back(mk(-512, 9, 1'b1));
    send_beat();
    drain(ir_high);
    check("single_no_empty", empty_cnt, 32'd0);

    // empty mask
    set_beat(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 2, 3, 4, 1, 2, 3, 4);
    send_beat();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("empty_done_cycle%0d", k), {31'b0, empty_done}, (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("empty_no_valid%0d", k), {31'b0, out_valid}, 32'd0);
    end
    @(negedge clk);
    check("empty_idle_next", {31'b0, in_ready}, 32'd1);
    check("empty_pulse_once", {31'b0, empty_done}, 32'd0);
    check("empty_cnt", empty_cnt, 32'd1);

    // backpressure then reset during OUT
    out_ready = 1'b0;
    set_beat(4'b0011, 4'b0000, 4'b1100, 4'b0000, 3, 3, 11, 11, 5, 6, -7, -8);
    send_beat();
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_sum", {22'b0, out_sum}, 32'd11);
      check("bp_hold_filter", {23'b0, out_filter}, 32'd3);
      check("bp_hold_last", {31'b0, out_last}, 32'd0);
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_out_sum", {22'b0, out_sum}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // new beat accepted normally after reset
    set_beat(4'b0000, 4'b0110, 4'b0000, 4'b1001, 0, 21, 0, 300, -50, 40, -60, 7);
    exp_q.push_back(mk(-20, 21, 1'b0));
    exp_q.push_back(mk(-43, 300, 1'b1));
    send_beat();
    drain(ir_high);
    check("final_empty_cnt", empty_cnt, 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/masked_psum_accumulator.md
Name: masked_psum_accumulator

Overview:
- Consumer-side partner of the adder-mask generator.
- Takes one registered adder-mask word, the per-macro filter indices and one signed partial sum per CIM macro.
- Walks the mask rows and emits one reduced sum per unique filter group over a valid/ready output stream.
- Sits between the macro array outputs and the output-channel accumulation buffer.

Parameters:
- NUM_MACRO, 16, number of CIM macros, which is also the mask row count and row width.
- OUT_CH, 512, number of output channels. Localparam BIT_OUT_CH = $clog2(OUT_CH).
- PSUM_W, 16, width of each signed macro partial sum. Localparam SUM_W = PSUM_W + $clog2(NUM_MACRO).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- ADDER_MASK  input  NUM_MACRO*NUM_MACRO  row i = bits [i*NUM_MACRO +: NUM_MACRO]; bit j set means macro j belongs to group i.
- WHICH_FILTER  input  NUM_MACRO*BIT_OUT_CH  filter index of macro i at [i*BIT_OUT_CH +: BIT_OUT_CH].
- PSUM  input  NUM_MACRO*PSUM_W  signed partial sum of macro i at [i*PSUM_W +: PSUM_W].
- out_valid  output  1  group result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  SUM_W  signed group sum.
- out_filter  output  BIT_OUT_CH  filter index of the group.
- out_last  output  1  marks the final group of the beat.
- empty_done  output  1  one-cycle pulse when a beat contains no nonzero row.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_filter=0, out_last=0, empty_done=0, row pointer=0, captured registers=0.
- State machine IDLE -> SCAN -> OUT:
  - IDLE: in_ready=1. A cycle with in_valid&&in_ready captures ADDER_MASK, WHICH_FILTER and PSUM, clears ptr to 0 and moves to SCAN. No other state accepts input; in_ready=0 outside IDLE.
  - SCAN: examines captured row[ptr], one row per cycle.
    - row[ptr]!=0: register out_sum = sum over j of (mask bit j ? sign-extended PSUM[j] : 0), out_filter = captured WHICH_FILTER[ptr], out_last = (no nonzero row at index > ptr). Then go to OUT.
    - row[ptr]==0 and ptr<NUM_MACRO-1: ptr+1, stay in SCAN.
    - row[ptr]==0 and ptr==NUM_MACRO-1: go to IDLE. Pulse empty_done for one cycle only if this beat emitted no group.
  - OUT: out_valid=1. out_sum, out_filter and out_last are held stable until out_ready.
    - On out_valid&&out_ready with out_last=1: go to IDLE.
    - Otherwise: ptr+1 and go to SCAN.
- Latency: capture edge at T. SCAN row 0 runs in cycle T+1. If row 0 is nonzero, out_valid is high in cycle T+2.
  - Minimum spacing between results is 2 cycles, plus 1 cycle per skipped zero row.
  - in_ready returns high in the cycle after the last handshake.
- Arithmetic: signed two's complement, sign extension to SUM_W. Overflow cannot occur by construction; no saturation.
- Mask contract: the generator guarantees each macro appears in exactly one nonzero row. This block does not check overlaps. An overlapping macro is summed into each row that contains it.
- Backpressure: out_ready low holds OUT indefinitely with outputs frozen. Input is not accepted while any group of the current beat is pending.
- Reset mid-operation: rst in any state returns to IDLE in the next cycle with reset values. The captured beat is discarded and out_valid drops without a handshake.
- Simultaneous events: a handshake with out_last=1 and in_valid in the same cycle does not capture; in_ready is 0 in that cycle. The beat is taken in the following IDLE cycle.

Test Plan:
- Bench overrides NUM_MACRO=4, PSUM_W=8, OUT_CH=512 for all scenarios.
- Two groups: filters {5,5,7,5}, rows {4'b1011, 0, 4'b0100, 0}, PSUM {10,-3,20,4}, out_ready=1.
  - Expected results: (filter 5, sum 11, last 0) then (filter 7, sum 20, last 1).
  - First out_valid 2 cycles after capture; no empty_done.
- All distinct: rows {0001,0010,0100,1000}, PSUM {-128,-128,127,1}. Expect sums -128, -128, 127, 1. Only the 4th result has last=1. in_ready=0 throughout.
- Single group at the extremes: row0=4'b1111, PSUM all -128. Expect one result, sum -512 (SUM_W=10 correct sign), last=1.
- Empty mask: all rows 0. Expect no out_valid, empty_done pulse exactly 4 cycles after capture, IDLE next.
- Backpressure and reset: hold out_ready=0 for 5 cycles; outputs must stay stable. Then assert rst during OUT: out_valid=0 and in_ready=1 the next cycle, and a new beat is accepted normally.
